// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and drain FSM encoding for the UART TX FIFO
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int DEF_DEPTH_LOG2     = 4;
    localparam int DEF_LAUNCH_TIMEOUT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port storage, synchronous write, asynchronous read
module uart_fifo_mem #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with drain FSM feeding a UART transmitter
// Optional level_o / almost_full_o outputs: define UART_TX_FIFO_LEVEL_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
    parameter int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic [UART_DATA_W-1:0] data_i,
    input  logic                   flush_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overflow_o,
    input  logic                   uart_busy_i,
    output logic                   uart_write_o,
    output logic [UART_DATA_W-1:0] uart_data_o
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0]    level_o,
    output logic                   almost_full_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(LAUNCH_TIMEOUT + 1);

    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [TW-1:0]         TIMER_LAST = TW'(LAUNCH_TIMEOUT - 1);

    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count;
    logic [TW-1:0]          timer;
    logic [UART_DATA_W-1:0] head;
    logic                   pop;
    logic                   push_ok;
    drain_state_t           state;
    drain_state_t           state_nx;

    uart_fifo_mem #(
        .AW (DEPTH_LOG2),
        .DW (UART_DATA_W)
    ) u_mem (
        .clk   (clock_i),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (data_i),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Launch keys off the registered empty flag; the live count guard keeps a
    // stale flag (e.g. just after a flush) from popping an empty FIFO.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty_o && (count != '0) && !uart_busy_i && !flush_i) begin
                    pop      = 1'b1;
                    state_nx = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (uart_busy_i) begin
                    state_nx = ST_BUSY;
                end else if (timer == TIMER_LAST) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!uart_busy_i) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign push_ok = push_i && !flush_i && ((count < CNT_DEPTH) || pop);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= ST_IDLE;
            timer        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full_o       <= 1'b0;
            empty_o      <= 1'b1;
            overflow_o   <= 1'b0;
            uart_write_o <= 1'b0;
            uart_data_o  <= '0;
        end else begin
            state        <= state_nx;
            timer        <= (state == ST_LAUNCH) ? timer + TW'(1) : '0;
            full_o       <= (count == CNT_DEPTH);
            empty_o      <= (count == '0);
            overflow_o   <= push_i && !flush_i && !push_ok;
            uart_write_o <= pop;
            if (pop) begin
                uart_data_o <= head;
            end
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (push_ok && !pop) begin
                    count <= count + CNT_ONE;
                end else if (pop && !push_ok) begin
                    count <= count - CNT_ONE;
                end
            end
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    localparam logic [DEPTH_LOG2:0] CNT_AFULL = (DEPTH_LOG2 + 1)'(DEPTH - 2);

    assign level_o       = count;
    assign almost_full_o = (count >= CNT_AFULL);
`endif

endmodule
